// File: rtl/unpacker_pkg.sv
// unpacker_pkg: shared constants for the float-to-Q2.30 unpacker
package unpacker_pkg;
  localparam int          W          = 32;
  localparam int          EXP_W      = 8;
  localparam int          FRAC_W     = 23;
  localparam int          FRAC_BITS  = 30;
  localparam logic [7:0]  FP_BIAS    = 8'd127;
  localparam logic [7:0]  SHIFT_ZERO = 8'd120;
  localparam logic [7:0]  EXP_MAX    = 8'hFF;
  localparam logic [31:0] SAT_POS    = 32'h7FFFFFFF;
  localparam logic [31:0] SAT_NEG    = 32'h80000000;
endpackage

// File: rtl/unpacker_if.sv
// unpacker_if: operand in (in_valid, data) and converted result out (out_valid, result, out_sign, out_special, out_ovf)
interface unpacker_if;
  logic        in_valid;
  logic [31:0] data;
  logic        out_valid;
  logic [31:0] result;
  logic        out_sign;
  logic        out_special;
  logic        out_ovf;
  modport master (output in_valid, data, input out_valid, result, out_sign, out_special, out_ovf);
  modport slave  (input in_valid, data, output out_valid, result, out_sign, out_special, out_ovf);
endinterface

// File: rtl/unpacker_shift.sv
// unpacker_shift: 24-bit mantissa to 31-bit magnitude barrel shifter
// ports: mant_i mantissa with hidden bit, exp_i biased exponent, mag_o magnitude, ovf_o magnitude >= 2.0
module unpacker_shift
  import unpacker_pkg::*;
(
  input  logic [23:0] mant_i,
  input  logic [7:0]  exp_i,
  output logic [30:0] mag_o,
  output logic        ovf_o
);
  logic [2:0] sl;
  logic [7:0] sr;
  assign sl    = 3'(exp_i - SHIFT_ZERO);
  assign sr    = SHIFT_ZERO - exp_i;
  assign ovf_o = exp_i > FP_BIAS;
  // left shifts stop at 7 below overflow; right shifts of 24+ clear every bit
  assign mag_o = ovf_o ? '0
               : exp_i >= SHIFT_ZERO ? {7'd0, mant_i} << sl
               : sr >= 8'd24 ? '0
               : {7'd0, mant_i} >> sr[4:0];
endmodule

// File: rtl/unpacker.sv
// unpacker: IEEE-754 single to Q2.30 fixed point, one registered stage
// ports: clk, rst_n async active-low, bus slave modport of unpacker_if
module unpacker
  import unpacker_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  unpacker_if.slave bus
);
  logic        s;
  logic [7:0]  e;
  logic [22:0] f;
  logic [30:0] mag;
  logic [31:0] m32;
  logic        big, nan, sat;
  logic [31:0] res_d, res_q;
  logic        ovf_d, ovf_q, special_d, special_q, sign_q, valid_q;
  assign {s, e, f} = bus.data;
  unpacker_shift u_shift (.mant_i({e != '0, f}), .exp_i(e), .mag_o(mag), .ovf_o(big));
  assign m32       = {1'b0, mag};
  assign nan       = e == EXP_MAX && f != '0;
  assign sat       = big && !nan;
  assign res_d     = nan ? '0 : sat ? (s ? SAT_NEG : SAT_POS) : s ? -m32 : m32;
  assign ovf_d     = sat || nan;
  assign special_d = e == FP_BIAS && f == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q   <= 1'b0;
      res_q     <= '0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q     <= res_d;
        sign_q    <= s;
        special_q <= special_d;
        ovf_q     <= ovf_d;
      end
    end
  assign bus.out_valid   = valid_q;
  assign bus.result      = res_q;
  assign bus.out_sign    = sign_q;
  assign bus.out_special = special_q;
  assign bus.out_ovf     = ovf_q;
endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: scoreboard bench for unpacker against a real-arithmetic float model
module tb_unpacker;
  typedef struct packed {
    logic [31:0] res;
    logic        sign;
    logic        special;
    logic        ovf;
  } exp_t;

  logic clk, rst_n;
  unpacker_if bus();
  unpacker dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t q[$];
  exp_t last, mx;
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, r);
    end
  endtask

  // value = (-1)^s * 1.f * 2^(e-127); Q2.30 code = value * 2^30 truncated toward zero
  function automatic exp_t model(input logic [31:0] d);
    exp_t x;
    int e, mag;
    real v;
    e = int'(d[30:23]);
    x.sign = d[31];
    x.special = (e == 127) && (d[22:0] == 0);
    x.ovf = 0;
    x.res = 0;
    if (e == 255) begin
      x.ovf = 1;
      if (d[22:0] == 0) x.res = d[31] ? 32'h80000000 : 32'h7FFFFFFF;
    end else if (e != 0) begin
      v = real'(8388608 + int'(d[22:0])) * (2.0 ** (e - 150)) * (2.0 ** 30);
      if (v >= 2.0 ** 31) begin
        x.ovf = 1;
        x.res = d[31] ? 32'h80000000 : 32'h7FFFFFFF;
      end else begin
        mag = $rtoi(v);
        x.res = d[31] ? 32'(-mag) : 32'(mag);
      end
    end
    return x;
  endfunction

  function automatic logic [31:0] rnd();
    logic [7:0] e;
    logic [22:0] f;
    int r;
    r = $urandom_range(0, 9);
    f = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
    e = (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : (r == 2) ? 8'd127 : 8'($urandom_range(90, 135));
    return {1'($urandom), e, f};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.data = d;
    if (v) q.push_back(model(d));
  endtask

  task automatic check_zero(input string n);
    check({n, "_valid"}, bus.out_valid, 0);
    check({n, "_result"}, bus.result, 0);
    check({n, "_sign"}, bus.out_sign, 0);
    check({n, "_special"}, bus.out_special, 0);
    check({n, "_ovf"}, bus.out_ovf, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) last = '0;
    else if (bus.out_valid) begin
      if (q.size() == 0) check("spurious_valid", bus.out_valid, 0);
      else begin
        mx = q.pop_front();
        check("result", bus.result, mx.res);
        check("sign", bus.out_sign, mx.sign);
        check("special", bus.out_special, mx.special);
        check("ovf", bus.out_ovf, mx.ovf);
        last = mx;
      end
    end else begin
      check("hold_result", bus.result, last.res);
      check("hold_sign", bus.out_sign, last.sign);
      check("hold_special", bus.out_special, last.special);
      check("hold_ovf", bus.out_ovf, last.ovf);
    end
  end

  logic [31:0] vec [12] = '{32'hBF800000, 32'h30800000, 32'h00000000, 32'h80000000,
                            32'h350637BD, 32'h3F000000, 32'h3F47AE14, 32'h3F1B74EE,
                            32'h40000000, 32'hFF800000, 32'h7FC00000, 32'h3FFFFFFF};

  initial begin
    rst_n = 0;
    bus.in_valid = 0;
    bus.data = 0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    bus.in_valid = 1;
    bus.data = 32'h3F800000;
    q.push_back(model(32'h3F800000));
    foreach (vec[i]) drive(1, vec[i]);
    drive(0, 32'h12345678);
    drive(0, 32'h3F800000);
    drive(0, 0);
    for (int i = 0; i < 400; i++) drive($urandom_range(0, 3) != 0, rnd());
    drive(1, 32'hBF800000);
    drive(1, rnd());
    #1;
    rst_n = 0;
    #1;
    check_zero("async_reset");
    q.delete();
    bus.in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    bus.in_valid = 1;
    bus.data = 32'h3F47AE14;
    q.push_back(model(32'h3F47AE14));
    for (int i = 0; i < 100; i++) drive($urandom_range(0, 3) != 0, rnd());
    drive(0, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as stated below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  data qualifier; data is sampled on clk when in_valid=1.
REQ-005 data  input  32  IEEE-754 single-precision operand (bit31 sign, bits30:23 exponent, bits22:0 fraction).
REQ-006 out_valid  output  1  high for one cycle per accepted operand.
REQ-007 result  output  32  signed two's-complement fixed point, Q2.30 (weight of LSB 2^-30; +1.0 = 0x40000000).
REQ-008 out_sign  output  1  sign bit of the accepted operand.
REQ-009 out_special  output  1  operand magnitude is exactly 1.0 (exponent 127, fraction 0).
REQ-010 out_ovf  output  1  result was saturated, or the operand was NaN.

Function
REQ-011 Latency SHALL be exactly 1 cycle: out_valid(t+1)=in_valid(t); result and flags update only when in_valid=1, otherwise they hold their last values.
REQ-012 No back-pressure: a new operand SHALL be accepted every cycle in_valid=1.
REQ-013 For 1<=e<=254 with M={1,fraction} (24 bits), the magnitude SHALL be M shifted left by (e-120) when e>=120, else M shifted right by (120-e) with truncation (bits shifted out discarded).
REQ-014 Exponents 0 (zero/denormal) and any e<=96 SHALL give magnitude 0; -0.0 SHALL give result 0x00000000.
REQ-015 Negative operands SHALL produce the two's-complement negation of the magnitude (-1.0 -> 0xC0000000).
REQ-016 Magnitude >= 2.0 (128<=e<=254, or e=255 with fraction 0) SHALL saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative) and set out_ovf.
REQ-017 NaN (e=255, fraction!=0) SHALL give result 0x00000000 with out_ovf=1.
REQ-018 out_special SHALL be 1 only for +/-1.0; out_sign SHALL equal data[31] for every accepted operand, including zero and NaN.
REQ-019 Values in (1.0, 2.0) SHALL convert without saturation (max magnitude 0x7FFFFF80 for e=127).

Reset
REQ-020 While rst_n=0, out_valid, result, out_sign, out_special and out_ovf SHALL be 0, asynchronously.
REQ-021 An operand presented in the cycle rst_n deasserts SHALL be accepted normally; an operand in flight at reset assertion SHALL be discarded.

Structure
REQ-022 A shared package SHALL hold FP_BIAS=127, FRAC_BITS=30, SHIFT_ZERO=120, the saturation constants 0x7FFFFFFF/0x80000000 and the float field widths.
REQ-023 Conversion SHALL be combinational in front of a single output register stage.
REQ-024 One sub-module, unpacker_shift (24-bit mantissa to 31-bit magnitude bidirectional barrel shifter with truncation and overflow detect), SHALL be instantiated.

Verification
REQ-025 0x3F800000 -> result 0x40000000, out_special=1, out_sign=0; 0xBF800000 -> 0xC0000000, out_special=1, out_sign=1.
REQ-026 0x30800000 (2^-30) -> 0x00000001; 0x00000000 and 0x80000000 -> 0x00000000; 0x350637BD -> 0x00000218.
REQ-027 0x3F000000 -> 0x20000000; 0x3F47AE14 -> 0x31EB8500; 0x3F1B74EE -> 0x26DD3B80; all with out_ovf=0.
REQ-028 0x40000000 (2.0) -> 0x7FFFFFFF, out_ovf=1; 0xFF800000 -> 0x80000000, out_ovf=1; 0x7FC00000 -> 0x00000000, out_ovf=1.
REQ-029 Back-to-back in_valid for 4 cycles -> four out_valid pulses, each result one cycle after its operand; in_valid low -> outputs hold.
REQ-030 Assert rst_n=0 mid-stream -> all outputs 0 immediately without a clock edge; stream resumes correctly after release.
